module2_rx: RTL
===============

Name: module2_rx

Overview:
- Receiving end of the module2 output bundle.
- Accepts the inverted field (P1 bits), the inverted field (P2 bits) and the 4-bit pass-through field, and undoes the inversion (re-inverts fields 1 and 2; field 3 is pass-through).
- Buffers restored words in a small FIFO and delivers them downstream over a valid/ready handshake.
- Sits between the module2 output stage and any consumer that can stall; maintains a level output and a delivered-word counter.

Parameters:
- P1, 4, width of field 1 (received inverted).
- P2, 5, width of field 2 (received inverted).
- DEPTH, 2, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in1  input  P1  field 1, inverted encoding.
- in2  input  P2  field 2, inverted encoding.
- in3  input  4  field 3, plain.
- out_valid  output  1  head word valid.
- out_ready  input  1  downstream accepts head word.
- out1  output  P1  restored field 1.
- out2  output  P2  restored field 2.
- out3  output  4  field 3.
- level  output  $clog2(DEPTH+1)  current occupancy.
- delivered  output  CNT_W  saturating count of words popped.

Behaviour:
- Reset (rst_n low, async assert, sync release):
  - Read/write pointers = 0; level = 0; delivered = 0.
  - All FIFO storage cleared to 0; out_valid = 0; out1/out2/out3 = 0.
  - in_ready = 1 (FIFO empty).
- Reset mid-operation: all stored words are discarded; no partial pop is visible afterwards.
- Push: occurs on a clk edge when in_valid && in_ready.
  - Stored entry = {~in1, ~in2, in3}; restoration happens at write time.
- in_ready = (level != DEPTH); combinational from registered level only, with no dependence on out_ready.
- Pop: occurs on a clk edge when out_valid && out_ready.
  - Read pointer advances modulo DEPTH.
  - delivered increments, saturating at 2^CNT_W-1.
- out_valid = (level != 0).
- out1/out2/out3 = entry at the read pointer. They hold stable while out_valid && !out_ready.
- Latency: a word pushed at edge N is visible with out_valid = 1 after edge N. There is no same-cycle bypass.
- Simultaneous events:
  - Push and pop in the same cycle: level unchanged; both pointers advance.
  - Full: in_ready = 0, so no push. A pop at full frees a slot; in_ready rises the following cycle.
  - Empty: pop impossible (out_valid = 0). A push at empty makes level 1 next cycle.
- Pointers wrap modulo DEPTH; level is tracked separately, so full and empty are unambiguous.
- in_valid is ignored when in_ready = 0. The upstream data is not captured, and no error is flagged; holding in_valid is the upstream's responsibility.
- Field widths P1 and P2 are independent; no arithmetic is performed across fields.

Test Plan:
1. Reset release, then one push with in1=4'hA, in2=5'h03, in3=4'h9, out_ready=1. Required:
   - out_valid rises one cycle after the push, with out1=4'h5, out2=5'h1C, out3=4'h9.
   - Word pops on that cycle; delivered=1; level returns to 0.
2. out_ready=0, push 3 words (DEPTH=2). Required:
   - in_ready drops after the 2nd push; the 3rd word is not captured; level=2.
   - Head stays word 1 until out_ready rises; words pop in order 1, 2.
3. Full FIFO with continuous in_valid and out_ready=1. Required:
   - Alternating pops and pushes; in_ready re-asserts one cycle after each pop.
   - Ordering preserved over 10 words, including pointer wrap.
4. Level 1, push and pop in the same cycle. Required: level stays 1; out fields update to the new word next cycle.
5. rst_n pulsed low mid-stream with level=2. Required:
   - Immediately out_valid=0, outputs=0, level=0, delivered=0, in_ready=1.
6. CNT_W=4, 20 pops. Required: delivered saturates at 4'hF and stays there.

Source files
------------

// File: rtl/module2_rx.sv
// module2_rx: receive side of the module2 output bundle.
// Re-inverts fields 1 and 2 at write time, passes field 3 through, buffers the
// restored words in a small FIFO and hands them downstream over valid/ready.
// Also reports the FIFO occupancy and a saturating count of delivered words.
module module2_rx #(
   parameter int P1    = 4,
   parameter int P2    = 5,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [P1-1:0]              in1,
   input  logic [P2-1:0]              in2,
   input  logic [3:0]                 in3,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [P1-1:0]              out1,
   output logic [P2-1:0]              out2,
   output logic [3:0]                 out3,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [CNT_W-1:0]           delivered
);

   // Pointer width; DEPTH is a power of two so pointers wrap by overflow.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int EW = P1 + P2 + 4;

   localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Stored word layout: {field1, field2, field3}, already restored.
   function automatic logic [EW-1:0] restore_word(input logic [P1-1:0] f1,
                                                  input logic [P2-1:0] f2,
                                                  input logic [3:0]    f3);
      return {~f1, ~f2, f3};
   endfunction

   // Increment that sticks at the all-ones value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [CNT_W-1:0] delivered_q, delivered_d;

   logic             push;
   logic             pop;
   logic [EW-1:0]    wr_word;
   logic [EW-1:0]    head_word;

   // Handshake decode: ready/valid derive only from the registered level.
   always_comb begin
      in_ready  = (level_q != FULL_LVL);
      out_valid = (level_q != '0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      wr_word   = restore_word(in1, in2, in3);
   end

   // Next-state for pointers, occupancy and the delivered counter.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      delivered_d = delivered_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d    = rd_ptr_q + AW'(1);
         delivered_d = sat_inc(delivered_q);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         delivered_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         delivered_q <= delivered_d;
      end
   end

   // FIFO storage; cleared on reset so the outputs read zero afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= wr_word;
      end
   end

   // Head of queue drives the output fields; stable while stalled.
   always_comb begin
      head_word = mem_q[rd_ptr_q];
      out1      = head_word[EW-1 -: P1];
      out2      = head_word[P2+3 -: P2];
      out3      = head_word[3:0];
      level     = level_q;
      delivered = delivered_q;
   end

endmodule
